// File: rtl/sw_debounce_bank_pkg.sv
// Shared types and defaults for the switch debounce bank; purely combinational, no flow control.
// Defines the per-channel filter state and the default filter and synchroniser depths.
package cpu_io_pkg;

    typedef enum logic {
        DB_IDLE   = 1'b0,
        DB_SETTLE = 1'b1
    } db_state_e;

    localparam int N_CH_DEFAULT        = 5;
    localparam int DB_CYCLES_DEFAULT   = 256;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int LONG_CYCLES_DEFAULT = 65536;

endpackage

// File: rtl/sw_debounce_bank_if.sv
// Bundle of raw switch inputs and the cleaned levels/pulses; no latency, no backpressure.
// master = the side driving sw_raw (board/testbench), slave = the debounce bank.
interface sw_debounce_bank_if #(
    parameter int N_CH = 5
);
    logic [N_CH-1:0] sw_raw;
    logic [N_CH-1:0] sw_level;
    logic [N_CH-1:0] sw_rise;
    logic [N_CH-1:0] sw_fall;
    logic            sw_any;
    logic [N_CH-1:0] sw_long;

    modport master (
        output sw_raw,
        input  sw_level, sw_rise, sw_fall, sw_any, sw_long
    );

    modport slave (
        input  sw_raw,
        output sw_level, sw_rise, sw_fall, sw_any, sw_long
    );
endinterface

// File: rtl/sw_debounce_ch.sv
// One channel: synchroniser, stability filter, edge pulses, optional long-press (SW_LONG_PRESS_EN).
// Latency SYNC_STAGES+DB_CYCLES cycles from a clean raw edge to level_o; no backpressure.
module sw_debounce_ch
    import cpu_io_pkg::*;
#(
    parameter int   DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int   SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter logic INIT_LEVEL  = 1'b0,
    parameter logic INVERT      = 1'b0,
    parameter int   LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_o
);

    if (DB_CYCLES < 2) begin : g_chk_db
        $error("sw_debounce_ch: DB_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("sw_debounce_ch: SYNC_STAGES must be >= 2");
    end

    localparam int               CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Reset value is pre-inversion so the corrected sample equals INIT_LEVEL.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL ^ INVERT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            level_q <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            DB_IDLE: begin
                cnt_d = '0;
                if (s != level_q) begin
                    state_d = DB_SETTLE;
                    cnt_d   = CNT_W'(1);
                end
            end
            DB_SETTLE: begin
                if (s == level_q) begin
                    // A bounce back to the accepted level restarts the filter from zero.
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                    level_d = s;
                    rise_d  = s;
                    fall_d  = ~s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef SW_LONG_PRESS_EN
    if (LONG_CYCLES < 1) begin : g_chk_long
        $error("sw_debounce_ch: LONG_CYCLES must be >= 1");
    end

    localparam int                HOLD_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    // Saturating at HOLD_MAX keeps the pulse single until the level drops.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!level_q) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (hold_q == HOLD_MAX - HOLD_W'(1));
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce_bank.sv
// N_CH independent debounce channels plus sw_any OR of all edge pulses; long-press via SW_LONG_PRESS_EN.
// Latency SYNC_STAGES+DB_CYCLES cycles raw edge to sw_level; inputs are sampled, no backpressure.
module sw_debounce_bank
    import cpu_io_pkg::*;
#(
    parameter int              N_CH        = N_CH_DEFAULT,
    parameter int              DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int              SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter logic [N_CH-1:0] INIT_LEVEL  = '0,
    parameter logic [N_CH-1:0] INVERT      = '0,
    parameter int              LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
    input logic              CLK,
    input logic              RST_N,
    sw_debounce_bank_if.slave bus
);

    logic [N_CH-1:0] level_w;
    logic [N_CH-1:0] rise_w;
    logic [N_CH-1:0] fall_w;
    logic [N_CH-1:0] long_w;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        sw_debounce_ch #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES),
            .INIT_LEVEL  (INIT_LEVEL[g]),
            .INVERT      (INVERT[g]),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_ch (
            .clk_i   (CLK),
            .rst_ni  (RST_N),
            .raw_i   (bus.sw_raw[g]),
            .level_o (level_w[g]),
            .rise_o  (rise_w[g]),
            .fall_o  (fall_w[g]),
            .long_o  (long_w[g])
        );
    end

    assign bus.sw_level = level_w;
    assign bus.sw_rise  = rise_w;
    assign bus.sw_fall  = fall_w;
    assign bus.sw_long  = long_w;
    assign bus.sw_any   = |(rise_w | fall_w);

endmodule

// File: tb/tb_sw_debounce_bank.sv
// Randomised + directed bench for sw_debounce_bank with a window-based reference model and scoreboard.
module tb_sw_debounce_bank;
    localparam int         N_CH  = 5;
    localparam int         DB    = 256;
    localparam int         SYNC  = 2;
    localparam logic [4:0] INIT  = 5'b00001;
    localparam logic [4:0] INV   = 5'b00010;
    localparam int         LONG  = 1000;
    localparam int         LAT   = SYNC + DB;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    sw_debounce_bank_if #(.N_CH(N_CH)) bus ();

    sw_debounce_bank #(
        .N_CH(N_CH), .DB_CYCLES(DB), .SYNC_STAGES(SYNC),
        .INIT_LEVEL(INIT), .INVERT(INV), .LONG_CYCLES(LONG)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0] level;
        logic [4:0] rise;
        logic [4:0] fall;
        logic       any;
        logic [4:0] lng;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] hist[$];
    logic [4:0] m_level;
    int         ecnt = 0;
    int         t_hi[N_CH];
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model state after reset: sync chain and filter history all equal INIT, hold timers restart.
    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC + DB; i++) hist.push_back(INIT);
        m_level = INIT;
        for (int c = 0; c < N_CH; c++) t_hi[c] = ecnt;
    endtask

    // One clock: level flips when the DB samples seen after the synchroniser all disagree with it.
    task automatic step();
        exp_t       e;
        logic [4:0] nl;
        bit         chg;
        @(posedge CLK);
        ecnt++;
        hist.push_front(bus.sw_raw ^ INV);
        void'(hist.pop_back());
        e  = '0;
        nl = m_level;
        for (int c = 0; c < N_CH; c++) begin
            chg = 1'b1;
            for (int j = SYNC; j < SYNC + DB; j++)
                if (hist[j][c] == m_level[c]) chg = 1'b0;
`ifdef SW_LONG_PRESS_EN
            if (m_level[c] && (ecnt - t_hi[c] == LONG)) e.lng[c] = 1'b1;
`endif
            if (chg) begin
                nl[c] = ~m_level[c];
                if (nl[c]) begin
                    e.rise[c] = 1'b1;
                    t_hi[c]   = ecnt;
                end else begin
                    e.fall[c] = 1'b1;
                end
            end
        end
        m_level = nl;
        e.level = nl;
        e.any   = |(e.rise | e.fall);
        exp_q.push_back(e);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int hold);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_level", int'(bus.sw_level), int'(INIT));
        chk("rst_pulses", int'({bus.sw_rise, bus.sw_fall, bus.sw_any, bus.sw_long}), 0);
        repeat (hold) @(posedge CLK);
        #2 RST_N = 1'b1;
        model_reset();
    endtask

    task automatic wait_level(input int c, input logic v, output int n);
        n = 0;
        while (bus.sw_level[c] !== v && n < LAT + 100) begin
            step();
            n++;
        end
    endtask

    // Scoreboard monitor: one expected entry per clock edge, compared on the falling edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge CLK);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {bus.sw_level, bus.sw_rise, bus.sw_fall, bus.sw_any, bus.sw_long};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t: level=%b rise=%b fall=%b any=%b long=%b, expected level=%b rise=%b fall=%b any=%b long=%b",
                             $time, a.level, a.rise, a.fall, a.any, a.lng,
                             e.level, e.rise, e.fall, e.any, e.lng);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t_lvl;
        int n_long;
        int t_long;
        logic [4:0] r;

        bus.sw_raw = 5'b00011;
        // Reset asserted mid-cycle, then idle inputs that match INIT after inversion.
        do_reset(3);
        run(600);
        chk("idle_level", int'(bus.sw_level), int'(INIT));

        // Clean press on channel 2.
        bus.sw_raw[2] = 1'b1;
        wait_level(2, 1'b1, n);
        chk("press2_latency", n, LAT);
        chk("press2_rise", int'(bus.sw_rise[2]), 1);
        chk("press2_any", int'(bus.sw_any), 1);
        run(20);

        // Release channel 2, then bounce: 100 high, 3 low, high held.
        bus.sw_raw[2] = 1'b0;
        wait_level(2, 1'b0, n);
        chk("release2_latency", n, LAT);
        chk("release2_fall", int'(bus.sw_fall[2]), 1);
        run(10);
        bus.sw_raw[2] = 1'b1;
        run(100);
        bus.sw_raw[2] = 1'b0;
        run(3);
        bus.sw_raw[2] = 1'b1;
        wait_level(2, 1'b1, n);
        chk("bounce2_latency", n, LAT);

        // Short pulse on channel 3 never reaches the level.
        bus.sw_raw[3] = 1'b1;
        run(200);
        bus.sw_raw[3] = 1'b0;
        run(300);
        chk("short3_level", int'(bus.sw_level[3]), 0);

        // Active-low channel 1 and channel 4 change together.
        bus.sw_raw[1] = 1'b0;
        bus.sw_raw[4] = 1'b1;
        wait_level(4, 1'b1, n);
        chk("simul4_latency", n, LAT);
        chk("simul1_level", int'(bus.sw_level[1]), 1);
        chk("simul_rise", int'({bus.sw_rise[1], bus.sw_rise[4]}), 3);
        run(10);
        bus.sw_raw[1] = 1'b1;
        bus.sw_raw[4] = 1'b0;
        wait_level(4, 1'b0, n);
        chk("simul_fall", int'({bus.sw_fall[1], bus.sw_fall[4]}), 3);
        run(10);

        // Reset in the middle of a pending change, then long hold.
        bus.sw_raw[2] = 1'b0;
        run(LAT + 20);
        bus.sw_raw[2] = 1'b1;
        run(150);
        do_reset(2);
        chk("midrst_level2", int'(bus.sw_level[2]), 0);
        wait_level(2, 1'b1, n);
        chk("postrst_latency", n, LAT);
        t_lvl = ecnt;
        n_long = 0;
        t_long = 0;
        for (int i = 0; i < 1300; i++) begin
            step();
            if (bus.sw_long[2] === 1'b1) begin
                n_long++;
                t_long = ecnt;
            end
        end
`ifdef SW_LONG_PRESS_EN
        chk("long2_count", n_long, 1);
        chk("long2_time", t_long - t_lvl, LONG);
`else
        chk("long2_count", n_long, 0);
`endif
        bus.sw_raw[2] = 1'b0;
        run(LAT + 10);

        // Random phase: mixed glitches, short pulses and long holds on random channel sets.
        for (int it = 0; it < 60; it++) begin
            r = 5'($urandom_range(1, 31));
            bus.sw_raw = bus.sw_raw ^ r;
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(1, 4);
                1:       n = $urandom_range(100, 260);
                2:       n = $urandom_range(250, 420);
                default: n = $urandom_range(1, 20);
            endcase
            run(n);
            if (it == 20 || it == 45) do_reset($urandom_range(1, 4));
        end
        bus.sw_raw = 5'b00011;
        run(LAT + 20);
        chk("final_level", int'(bus.sw_level), int'(INIT));

        @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
